// File: rtl/arithmetic_and_memory_unit_pkg.sv
// Shared widths, instruction field positions and ALU encodings for the
// arithmetic_and_memory_unit datapath and its companion modules.
package arithmetic_and_memory_unit_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int MEM_DEPTH  = 64;
  localparam int MEM_ADDR_W = 6;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;
  localparam int SHAMT_MSB  = 10;
  localparam int SHAMT_LSB  = 6;

  localparam logic [REG_ADDR_W-1:0] LINK_REG = 5'd31;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_NOT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRA = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    SRC_RT         = 2'b00,
    SRC_SEXT_IMM   = 2'b01,
    SRC_ZEXT_IMM   = 2'b10,
    SRC_ZEXT_SHAMT = 2'b11
  } alu_src_e;

  typedef struct packed {
    logic carry;
    logic zero;
    logic sign;
  } alu_flags_t;

endpackage

// File: rtl/arithmetic_and_memory_unit_register_file.sv
// 32x32 register file: two combinational read ports, one clocked write port,
// register 0 hard-wired to zero, whole array cleared by the async reset.
module register_file
  import arithmetic_and_memory_unit_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] rs_addr,
  input  logic [REG_ADDR_W-1:0] rt_addr,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic                  wr_en,
  input  logic [DATA_W-1:0]     wr_data,
  output logic [DATA_W-1:0]     rs_data,
  output logic [DATA_W-1:0]     rt_data
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  // Entry 0 is never updated, so it holds the zero it got at reset.
  always_comb begin
    regs_d = regs_q;
    if (wr_en && (wr_addr != '0)) begin
      regs_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rs_data = regs_q[rs_addr];
  assign rt_data = regs_q[rt_addr];

endmodule

// File: rtl/program_counter_unit.sv
// Instruction address register feeding PCin of arithmetic_and_memory_unit;
// loads next_address every rising edge and clears asynchronously on reset.
module program_counter_unit
  import arithmetic_and_memory_unit_pkg::*;
(
  input  logic [DATA_W-1:0] next_address,
  input  logic              clk,
  input  logic              reset,
  output logic [DATA_W-1:0] PCin
);

  logic [DATA_W-1:0] pc_q;
  logic [DATA_W-1:0] pc_d;

  assign pc_d = next_address;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign PCin = pc_q;

endmodule

// File: rtl/arithmetic_and_memory_unit.sv
// Single-cycle datapath slice: instruction ROM, register file, ALU, data memory
// and write-back mux. ROM words arrive through ROM_IMAGE (word k at [32k+:32]).
module arithmetic_and_memory_unit
  import arithmetic_and_memory_unit_pkg::*;
#(
  parameter logic [MEM_DEPTH*DATA_W-1:0] ROM_IMAGE = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] PCin,
  input  logic              RegWrite,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              MemtoReg,
  input  logic              DataPCSel,
  input  logic              RegSelect,
  input  logic [2:0]        ALUop,
  input  logic [1:0]        ALUinSel,
  output logic [DATA_W-1:0] ALUresult,
  output logic [DATA_W-1:0] address,
  output logic [DATA_W-1:0] data_to_mem,
  output logic [2:0]        flags,
  output logic [5:0]        opcode
);

  logic [DATA_W-1:0]     rom [MEM_DEPTH];
  logic [DATA_W-1:0]     instr;
  logic [REG_ADDR_W-1:0] rs;
  logic [REG_ADDR_W-1:0] rt;
  logic [15:0]           imm16;
  logic [4:0]            shamt;
  logic [DATA_W-1:0]     rs_data;
  logic [DATA_W-1:0]     rt_data;
  logic [DATA_W-1:0]     operand_b;
  logic [DATA_W:0]       wide_sum;
  logic [DATA_W-1:0]     alu_result;
  logic                  alu_carry;
  alu_flags_t            alu_flags;
  logic [MEM_ADDR_W-1:0] mem_index;
  logic [DATA_W-1:0]     mem_rdata;
  logic [DATA_W-1:0]     wb_base;
  logic [REG_ADDR_W-1:0] dest_reg;
  logic [DATA_W-1:0]     dmem_q [MEM_DEPTH];
  logic [DATA_W-1:0]     dmem_d [MEM_DEPTH];

  for (genvar g = 0; g < MEM_DEPTH; g++) begin : g_rom
    assign rom[g] = ROM_IMAGE[g*DATA_W +: DATA_W];
  end

  assign instr  = rom[PCin[MEM_ADDR_W-1:0]];
  assign opcode = instr[OPCODE_MSB:OPCODE_LSB];
  assign rs     = instr[RS_MSB:RS_LSB];
  assign rt     = instr[RT_MSB:RT_LSB];
  assign imm16  = instr[IMM_MSB:IMM_LSB];
  assign shamt  = instr[SHAMT_MSB:SHAMT_LSB];

  register_file u_regfile (
    .clk     (clk),
    .reset   (reset),
    .rs_addr (rs),
    .rt_addr (rt),
    .wr_addr (dest_reg),
    .wr_en   (RegWrite),
    .wr_data (data_to_mem),
    .rs_data (rs_data),
    .rt_data (rt_data)
  );

  always_comb begin
    operand_b = '0;
    case (alu_src_e'(ALUinSel))
      SRC_RT:         operand_b = rt_data;
      SRC_SEXT_IMM:   operand_b = {{16{imm16[15]}}, imm16};
      SRC_ZEXT_IMM:   operand_b = {16'b0, imm16};
      SRC_ZEXT_SHAMT: operand_b = {27'b0, shamt};
      default:        operand_b = '0;
    endcase
  end

  // Subtraction is A + ~B + 1, so bit 32 is the no-borrow carry.
  always_comb begin
    wide_sum   = '0;
    alu_result = '0;
    alu_carry  = 1'b0;
    case (alu_op_e'(ALUop))
      ALU_ADD: begin
        wide_sum   = {1'b0, rs_data} + {1'b0, operand_b};
        alu_result = wide_sum[DATA_W-1:0];
        alu_carry  = wide_sum[DATA_W];
      end
      ALU_SUB: begin
        wide_sum   = {1'b0, rs_data} + {1'b0, ~operand_b} + 33'd1;
        alu_result = wide_sum[DATA_W-1:0];
        alu_carry  = wide_sum[DATA_W];
      end
      ALU_AND: alu_result = rs_data & operand_b;
      ALU_OR:  alu_result = rs_data | operand_b;
      ALU_XOR: alu_result = rs_data ^ operand_b;
      ALU_NOT: alu_result = ~rs_data;
      ALU_SLL: alu_result = rs_data << operand_b[4:0];
      ALU_SRA: alu_result = $unsigned($signed(rs_data) >>> operand_b[4:0]);
      default: alu_result = '0;
    endcase
  end

  assign alu_flags.carry = alu_carry;
  assign alu_flags.zero  = (alu_result == '0);
  assign alu_flags.sign  = alu_result[DATA_W-1];
  assign flags           = alu_flags;
  assign ALUresult       = alu_result;
  assign address         = alu_result;
  assign mem_index       = alu_result[MEM_ADDR_W-1:0];

  always_comb begin
    dmem_d = dmem_q;
    if (MemWrite) begin
      dmem_d[mem_index] = rt_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dmem_q <= '{default: '0};
    end else begin
      dmem_q <= dmem_d;
    end
  end

  // Reads come from the stored array, so a same-cycle write is seen only after the edge.
  assign mem_rdata   = MemRead ? dmem_q[mem_index] : '0;
  assign wb_base     = MemtoReg ? mem_rdata : alu_result;
  assign data_to_mem = DataPCSel ? (PCin + 32'd1) : wb_base;
  assign dest_reg    = RegSelect ? LINK_REG : rt;

endmodule

// File: tb/tb_arithmetic_and_memory_unit.sv
// Self-checking bench: directed scenarios followed by random cycles, all checked
// against an array-based model of registers, data memory and ALU arithmetic.
module tb_arithmetic_and_memory_unit;

  localparam logic [5:0] C_RW   = 6'b100000;
  localparam logic [5:0] C_MR   = 6'b010000;
  localparam logic [5:0] C_MW   = 6'b001000;
  localparam logic [5:0] C_M2R  = 6'b000100;
  localparam logic [5:0] C_DPS  = 6'b000010;
  localparam logic [5:0] C_RSEL = 6'b000001;

  // Words 32..63 copy R31 into R[k-32] (rs=31, imm=0); a few words are hand-placed.
  function automatic logic [2047:0] build_rom();
    logic [2047:0] img;
    logic [31:0]   w;
    img = '0;
    for (int k = 0; k < 64; k++) begin
      if (k >= 32) w = {6'h00, 5'd31, 5'(k - 32), 16'h0000};
      else         w = {6'(k * 5 + 1), 5'(k * 3), 5'(k * 7 + 1), 16'(k * 40503) ^ 16'h5A5A};
      img[k*32 +: 32] = w;
    end
    img[1*32 +: 32] = 32'h8C22_1234;
    img[4*32 +: 32] = {6'h08, 5'd5, 5'd6, 16'hFFFF};
    img[5*32 +: 32] = {6'h00, 5'd7, 5'd8, 16'h0000};
    img[6*32 +: 32] = {6'h2B, 5'd0, 5'd9, 16'h0003};
    return img;
  endfunction

  localparam logic [2047:0] ROM_IMAGE = build_rom();

  typedef struct {
    logic [31:0] alu;
    logic [2:0]  flags;
    logic [31:0] wb;
    logic [5:0]  opc;
    logic [4:0]  dest;
    logic [31:0] store;
  } expect_t;

  logic        clk;
  logic        reset;
  logic [31:0] pc_in;
  logic        reg_write, mem_read, mem_write, mem_to_reg, data_pc_sel, reg_select;
  logic [2:0]  alu_op;
  logic [1:0]  alu_in_sel;
  logic [31:0] alu_result, address, data_to_mem;
  logic [2:0]  flags;
  logic [5:0]  opcode;
  logic [31:0] pc_next, pc_out, pc_expect;

  logic [31:0] reg_m [32];
  logic [31:0] mem_m [64];
  int compared;
  int mismatched;

  arithmetic_and_memory_unit #(.ROM_IMAGE(ROM_IMAGE)) dut (
    .clk         (clk),
    .reset       (reset),
    .PCin        (pc_in),
    .RegWrite    (reg_write),
    .MemRead     (mem_read),
    .MemWrite    (mem_write),
    .MemtoReg    (mem_to_reg),
    .DataPCSel   (data_pc_sel),
    .RegSelect   (reg_select),
    .ALUop       (alu_op),
    .ALUinSel    (alu_in_sel),
    .ALUresult   (alu_result),
    .address     (address),
    .data_to_mem (data_to_mem),
    .flags       (flags),
    .opcode      (opcode)
  );

  program_counter_unit u_pc (
    .next_address (pc_next),
    .clk          (clk),
    .reset        (reset),
    .PCin         (pc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) reg_m[i] = '0;
    for (int i = 0; i < 64; i++) mem_m[i] = '0;
    pc_expect = '0;
  endtask

  function automatic expect_t model_eval();
    expect_t     e;
    logic [31:0] word, a, b, r, rd;
    logic        c;
    word = ROM_IMAGE[int'(pc_in[5:0])*32 +: 32];
    a = reg_m[word[25:21]];
    case (alu_in_sel)
      2'd0:    b = reg_m[word[20:16]];
      2'd1:    b = 32'(int'($signed(word[15:0])));
      2'd2:    b = 32'(word[15:0]);
      default: b = 32'(word[10:6]);
    endcase
    c = 1'b0;
    case (alu_op)
      3'd0: begin r = a + b; c = (64'(a) + 64'(b)) >= 64'h1_0000_0000; end
      3'd1: begin r = a - b; c = (a >= b); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ~a;
      3'd6: r = a << b[4:0];
      default: r = 32'($signed(a) >>> b[4:0]);
    endcase
    rd       = mem_read ? mem_m[r[5:0]] : 32'd0;
    e.alu    = r;
    e.flags  = {c, r == 32'd0, r[31]};
    e.wb     = data_pc_sel ? pc_in + 32'd1 : (mem_to_reg ? rd : r);
    e.opc    = word[31:26];
    e.dest   = reg_select ? 5'd31 : word[20:16];
    e.store  = reg_m[word[20:16]];
    return e;
  endfunction

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    expect_t e;
    e = model_eval();
    check_value({tag, "_alu"},    alu_result,          e.alu);
    check_value({tag, "_addr"},   address,             e.alu);
    check_value({tag, "_wb"},     data_to_mem,         e.wb);
    check_value({tag, "_flags"},  {29'd0, flags},      {29'd0, e.flags});
    check_value({tag, "_opcode"}, {26'd0, opcode},     {26'd0, e.opc});
    check_value({tag, "_pc"},     pc_out,              pc_expect);
  endtask

  task automatic apply_stimulus(input logic [31:0] pc, input logic [5:0] ctrl,
                                input logic [2:0] op, input logic [1:0] sel, input string tag);
    pc_in = pc;
    {reg_write, mem_read, mem_write, mem_to_reg, data_pc_sel, reg_select} = ctrl;
    alu_op     = op;
    alu_in_sel = sel;
    #1;
    check_outputs(tag);
  endtask

  // Model writes are computed from pre-edge state, then applied after the edge.
  task automatic commit_edge();
    expect_t e;
    e = model_eval();
    pc_next = $urandom();
    @(posedge clk);
    if (mem_write) mem_m[e.alu[5:0]] = e.store;
    if (reg_write && (e.dest != 5'd0)) reg_m[e.dest] = e.wb;
    pc_expect = pc_next;
    @(negedge clk);
  endtask

  task automatic load_reg(input logic [4:0] t, input logic [31:0] v);
    apply_stimulus(v - 32'd1, C_RW | C_DPS | C_RSEL, 3'b000, 2'b00, "ld_link");
    commit_edge();
    apply_stimulus(32'd32 + 32'(t), C_RW, 3'b110, 2'b11, "ld_move");
    commit_edge();
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b0;
    pc_next    = 32'h0000_0040;
    model_reset();
    @(negedge clk);
    apply_stimulus(32'd1, 6'd0, 3'b000, 2'b00, "reset");
    check_value("reset_alu_zero", alu_result, 32'd0);
    check_value("reset_flags_010", {29'd0, flags}, 32'd2);
    check_value("reset_opcode_rom1", {26'd0, opcode}, 32'h23);
    check_value("reset_pc_zero", pc_out, 32'd0);
    apply_stimulus(32'd1, C_MR | C_M2R, 3'b000, 2'b00, "reset_m2r");
    check_value("reset_mem0_zero", data_to_mem, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Link write: R31 <= PCin + 1.
    apply_stimulus(32'd2, C_RW | C_DPS | C_RSEL, 3'b000, 2'b00, "link");
    check_value("link_wb_before_edge", data_to_mem, 32'd3);
    commit_edge();
    apply_stimulus(32'd32, 6'd0, 3'b000, 2'b10, "read_r31");
    check_value("r31_is_3", alu_result, 32'd3);
    commit_edge();

    // R0 ignores writes: NOT R0 must stay all ones.
    apply_stimulus(32'd32, C_RW | C_DPS, 3'b000, 2'b00, "write_r0");
    commit_edge();
    apply_stimulus(32'd0, 6'd0, 3'b101, 2'b00, "not_r0");
    check_value("not_r0_ones", alu_result, 32'hFFFF_FFFF);
    commit_edge();

    load_reg(5'd5, 32'd5);
    apply_stimulus(32'd4, 6'd0, 3'b000, 2'b01, "add_sext");
    check_value("add_sext_result", alu_result, 32'd4);
    check_value("add_sext_flags", {29'd0, flags}, 32'd4);
    commit_edge();

    load_reg(5'd7, 32'd7);
    load_reg(5'd8, 32'd7);
    apply_stimulus(32'd5, 6'd0, 3'b001, 2'b00, "sub_equal");
    check_value("sub_equal_result", alu_result, 32'd0);
    check_value("sub_equal_flags", {29'd0, flags}, 32'd6);
    commit_edge();

    load_reg(5'd9, 32'hDEAD_BEEF);
    apply_stimulus(32'd6, C_MW | C_MR | C_M2R, 3'b000, 2'b10, "store");
    check_value("store_addr_3", address, 32'd3);
    check_value("store_read_old", data_to_mem, 32'd0);
    commit_edge();
    apply_stimulus(32'd6, C_MR | C_M2R, 3'b000, 2'b10, "load");
    check_value("load_deadbeef", data_to_mem, 32'hDEAD_BEEF);

    // Asynchronous reset in the middle of a load cycle.
    #1;
    reset = 1'b0;
    model_reset();
    #1;
    check_value("async_mem3_zero", data_to_mem, 32'd0);
    check_value("async_pc_zero", pc_out, 32'd0);
    apply_stimulus(32'd41, 6'd0, 3'b011, 2'b00, "async_regs");
    check_value("async_r31_r9_zero", alu_result, 32'd0);
    apply_stimulus(32'd100, C_RW | C_DPS | C_RSEL | C_MW, 3'b000, 2'b00, "blocked");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    apply_stimulus(32'd32, 6'd0, 3'b000, 2'b10, "after_block");
    check_value("blocked_r31_zero", alu_result, 32'd0);
    commit_edge();

    for (int i = 0; i < 250; i++) begin
      apply_stimulus($urandom(), 6'($urandom()), 3'($urandom()), 2'($urandom()), "rand");
      commit_edge();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/arithmetic_and_memory_unit.md
ARITHMETIC_AND_MEMORY_UNIT -- requirements
Module: arithmetic_and_memory_unit

Interface
REQ-001 The unit SHALL provide: clk  in  1  single system clock; all state updates on rising edge.
REQ-002 reset  in  1  asynchronous, active-low reset.
REQ-003 PCin  in  32  word address of the current instruction, driven by companion program_counter_unit.
REQ-004 RegWrite, MemRead, MemWrite, MemtoReg, DataPCSel, RegSelect  in  1 each  control strobes.
REQ-005 ALUop  in  3  ALU operation select.
REQ-006 ALUinSel  in  2  ALU operand-B source select.
REQ-007 ALUresult  out  32  combinational ALU output.
REQ-008 address  out  32  data-memory address, equal to ALUresult.
REQ-009 data_to_mem  out  32  final write-back value.
REQ-010 flags  out  3  {carry, zero, sign} of the current ALU result.
REQ-011 opcode  out  6  instr[31:26] of the fetched instruction.

Function
REQ-012 Instruction memory: 64x32 ROM, combinational read at PCin[5:0], loaded at elaboration from "instructions.mem" (hex); unwritten words read 0.
REQ-013 Instruction fields: opcode=[31:26], rs=[25:21], rt=[20:16], imm16=[15:0], shamt=[10:6].
REQ-014 Register file: 32x32, two combinational read ports (rs, rt); register 0 always reads 0 and ignores writes.
REQ-015 Operand A = R[rs]; operand B by ALUinSel: 00 R[rt], 01 sign-extended imm16, 10 zero-extended imm16, 11 zero-extended shamt.
REQ-016 ALUop: 000 ADD, 001 SUB (A-B), 010 AND, 011 OR, 100 XOR, 101 NOT A, 110 SLL A by B[4:0], 111 SRA A by B[4:0].
REQ-017 carry = bit 32 of 33-bit ADD/SUB (SUB carry = no-borrow); 0 for all other ops; zero = (ALUresult==0); sign = ALUresult[31].
REQ-018 Data memory: 64x32, word index address[5:0]; read combinational, yields 0 when MemRead=0; write on rising clk when MemWrite=1, data = R[rt].
REQ-019 Write-back mux: base = MemtoReg ? memory read data : ALUresult; data_to_mem = DataPCSel ? PCin+1 : base.
REQ-020 Destination = RegSelect ? 31 : rt; written with data_to_mem on rising clk when RegWrite=1.
REQ-021 Simultaneous MemRead and MemWrite to same word: read returns old value this cycle.
REQ-022 Same-cycle register read/write of one register: read returns old value until the edge.
REQ-023 All outputs are combinational from PCin, state and controls; no extra pipeline latency.

Reset
REQ-024 reset low SHALL asynchronously clear all 32 registers and all 64 data-memory words; instruction ROM is unaffected.
REQ-025 After reset with all controls 0 and ALUinSel=00: ALUresult=0, address=0, flags=3'b010, data_to_mem=0 (MemtoReg=0) or mem word 0 = 0 (MemtoReg=1).
REQ-026 Writes are blocked while reset is low; release is synchronous-safe (first write on first rising edge after release).

Structure
REQ-027 Shared package: ALUop codes, ALUinSel codes, DATA_W=32, REG_ADDR_W=5, MEM_DEPTH=64, opcode field positions.
REQ-028 One sub-module register_file (32x32, 2R1W, async clear); ALU and memories inline.
REQ-029 program_counter_unit is a separate module: ports (next_address in 32, clk, reset, PCin out 32); PCin <= next_address on rising clk; PCin=0 on reset (asynchronous, active-low).

Verification
REQ-030 Reset pulse, PCin=1, all controls 0 -> ALUresult=0, address=0, flags=010, opcode=ROM[1][31:26].
REQ-031 RegWrite=1, DataPCSel=1, RegSelect=1, PCin=2, one rising edge -> R31=3; data_to_mem=3 before the edge.
REQ-032 R[rs]=5, ALUinSel=01, imm16=0xFFFF, ALUop=000 -> ALUresult=4, carry=1, zero=0, sign=0.
REQ-033 R[rs]=7, R[rt]=7, ALUop=001, ALUinSel=00 -> ALUresult=0, flags=110.
REQ-034 MemWrite=1, address=3, R[rt]=0xDEADBEEF, edge; then MemRead=1, MemtoReg=1 -> data_to_mem=0xDEADBEEF.
REQ-035 Assert reset mid-operation after REQ-034 -> memory word 3 and all registers read 0 immediately, PCin=0.
